array_multiplier: RTL and testbench
===================================

Name: array_multiplier

Overview:
- Unsigned WIDTH x WIDTH array multiplier built from a structural grid of AND partial-product gates and half/full-adder cells.
- Product and a valid flag are registered once per clock.
- Used as a small arithmetic leaf in datapaths; default configuration is 4x4 producing 8 bits.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..16); product width is 2*WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  input  1  qualifies a and b for capture this cycle.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- product  output  2*WIDTH  registered unsigned product a*b.
- out_valid  output  1  high for one cycle per accepted operand pair; product is valid while it is high.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: when rst=1 at a rising edge, product<=0 and out_valid<=0, regardless of in_valid. No asynchronous behaviour.
- Partial products: pp[i][j] = a[j] & b[i] for i,j in 0..WIDTH-1.
- Array structure:
  - Row 0 is pp[0], shifted by 0.
  - Each subsequent row i adds pp[i], shifted left by i, to the running sum using a ripple chain of WIDTH adder cells.
  - The least-significant position of a row with no carry-in uses a half adder.
  - The carry-out of each row becomes the MSB of that row's sum.
  - Bit k of the final product is the LSB of row k for k < WIDTH-1; the remaining upper bits come from the last row's sum and carry.
  - Implementation uses generate loops of explicit half_adder/full_adder cells (submodules or equivalent gate expressions). The * operator is not used.
- Arithmetic: the result is exact and unsigned; 2*WIDTH bits always suffice, so no overflow or truncation occurs.
- Latency: the combinational array evaluates a,b. At the rising edge with rst=0:
  - if in_valid=1: product <= a*b and out_valid <= 1;
  - if in_valid=0: product holds its previous value and out_valid <= 0.
  - Latency is exactly 1 cycle from capture edge to output.
- Throughput: one new operand pair per cycle; back-to-back in_valid cycles produce back-to-back out_valid results in order.
- No backpressure; the output is never stalled.
- Simultaneous rst=1 and in_valid=1: reset wins; the operands are discarded.
- Reset mid-stream: any result that would have appeared on the next edge is discarded. The first valid output after reset deasserts comes one cycle after the first accepted in_valid.
- Operand changes while in_valid=0 have no effect on product.
- X/Z inputs are not handled specially.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, a=4'hF, b=4'hF -> product=8'h00, out_valid=0 throughout.
- Exhaustive: for a=0..15, b=0..15, one pair per cycle with in_valid=1 -> each following cycle product==a*b and out_valid=1; e.g. 3*5=8'd15, 15*15=8'b11100001, 8*2=8'd16.
- Zero/identity: a=0, b=13 -> 0; a=1, b=13 -> 13; a=13, b=1 -> 13. Commutativity check: a=7, b=9 and a=9, b=7 both give 8'd63.
- Valid gating: capture 6*7=42, then in_valid=0 with a=15, b=15 for 3 cycles -> product stays 8'd42, out_valid=0 on those cycles.
- Mid-stream reset: stream 2*3, 4*5, assert rst on the edge that would capture 4*5 -> product=0, out_valid=0. After release, 10*10 -> 8'd100 one cycle later.
- Parameter: WIDTH=8, a=255, b=255 -> product=16'hFE01; a=128, b=2 -> 16'd256.

Source files
------------

// File: rtl/array_multiplier.sv
// array_multiplier
// ----------------
// Unsigned WIDTH x WIDTH array multiplier. The product is formed by a grid of
// AND partial-product gates feeding rows of ripple half/full-adder cells, and
// is registered together with a valid flag once per clock.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset (clears product and out_valid)
//   in_valid   qualifies a/b for capture on this rising edge
//   a, b       unsigned operands, WIDTH bits each
//   product    registered a*b, 2*WIDTH bits; holds while no new pair arrives
//   out_valid  one-cycle pulse per accepted operand pair
//
// Handshake: a pair is accepted on every rising edge where in_valid=1 and
// rst=0; there is no ready/backpressure. The result appears on product with
// out_valid=1 exactly one cycle later, in order. Reset wins over in_valid.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module array_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               out_valid
);

  logic [2*WIDTH-1:0] array_product;

  // Each row holds a WIDTH+1 bit sum: WIDTH sum bits plus the row carry-out as
  // MSB. Bit 0 of a row is final (it is product bit i); the upper WIDTH bits
  // are passed down and added to the next partial-product row, which is
  // shifted left by one relative to it.
  genvar i, j;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_row
      logic [WIDTH:0]   row_sum;
      logic [WIDTH-1:0] pp;

      // pp[j] = a[j] & b[i]
      assign pp = a & {WIDTH{b[i]}};

      if (i == 0) begin : g_first
        assign row_sum = {1'b0, pp};
      end else begin : g_add
        logic [WIDTH-1:0] prev_hi;
        assign prev_hi = g_row[i-1].row_sum[WIDTH:1];

        // Carries live in per-cell scalars so the ripple chain is not a
        // vector that depends on its own bits.
        for (j = 0; j < WIDTH; j++) begin : g_col
          logic c_out;
          if (j == 0) begin : g_ha
            half_adder u_ha (
              .x (prev_hi[0]),
              .y (pp[0]),
              .s (row_sum[0]),
              .c (c_out)
            );
          end else begin : g_fa
            full_adder u_fa (
              .x  (prev_hi[j]),
              .y  (pp[j]),
              .ci (g_col[j-1].c_out),
              .s  (row_sum[j]),
              .co (c_out)
            );
          end
        end

        assign row_sum[WIDTH] = g_col[WIDTH-1].c_out;
      end
    end

    // Low product bits drop out of each row's LSB; the last row supplies the
    // top WIDTH+1 bits.
    for (i = 0; i < WIDTH - 1; i++) begin : g_low_bits
      assign array_product[i] = g_row[i].row_sum[0];
    end
  endgenerate

  assign array_product[2*WIDTH-1:WIDTH-1] = g_row[WIDTH-1].row_sum;

  // Output registers
  logic [2*WIDTH-1:0] product_d, product_q;
  logic               out_valid_d, out_valid_q;

  always_comb begin
    product_d   = product_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      product_d   = array_product;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign product   = product_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_array_multiplier.sv
// Bench for array_multiplier: a 4-bit instance driven by directed and
// exhaustive/random stimulus, plus an 8-bit instance fed corner cases then
// random pairs. Expected products come from plain integer multiplication.

module tb_array_multiplier;

  // Clock / reset
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic        in_valid;
  logic [3:0]  a, b;
  logic [7:0]  product;
  logic        out_valid;

  logic        in_valid8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;
  logic        out_valid8;

  array_multiplier #(.WIDTH(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .product   (product),
    .out_valid (out_valid)
  );

  array_multiplier #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .a         (a8),
    .b         (b8),
    .product   (product8),
    .out_valid (out_valid8)
  );

  // Scoreboard state
  logic [7:0]  exp_q[$];
  logic [15:0] exp8_q[$];
  logic [15:0] pend8[$];
  logic [7:0]  held;
  logic [15:0] held8;
  logic        quiet8;
  int          n_checks;
  int          n_fail;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    held     = '0;
    held8    = '0;
    quiet8   = 1'b0;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: apply one cycle of inputs at the falling edge and record the
  // expected results of any pair that will be accepted.
  task automatic step(input logic r, input logic v, input logic [3:0] x, input logic [3:0] y);
    logic [15:0] p;
    logic        v8l;
    logic [7:0]  x8, y8;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = x;
    b        = y;
    if (pend8.size() > 0) begin
      p   = pend8.pop_front();
      v8l = 1'b1;
      x8  = p[15:8];
      y8  = p[7:0];
    end else begin
      v8l = quiet8 ? 1'b0 : 1'($urandom_range(0, 1));
      x8  = 8'($urandom_range(0, 255));
      y8  = 8'($urandom_range(0, 255));
    end
    in_valid8 = v8l;
    a8        = x8;
    b8        = y8;
    if (!r && v)   exp_q.push_back(8'(int'(x) * int'(y)));
    if (!r && v8l) exp8_q.push_back(16'(int'(x8) * int'(y8)));
  endtask

  // Monitor for the 4-bit instance
  always @(posedge clk) begin
    logic [7:0] e;
    #1;
    if (rst) begin
      check("rst_valid4", {15'd0, out_valid}, 16'd0);
      check("rst_product4", {8'd0, product}, 16'd0);
      held = '0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid4", {15'd0, out_valid}, 16'd0);
      end else begin
        e = exp_q.pop_front();
        check("product4", {8'd0, product}, {8'd0, e});
        held = e;
      end
    end else begin
      check("hold4", {8'd0, product}, {8'd0, held});
    end
  end

  // Monitor for the 8-bit instance
  always @(posedge clk) begin
    logic [15:0] e;
    #1;
    if (rst) begin
      check("rst_valid8", {15'd0, out_valid8}, 16'd0);
      check("rst_product8", product8, 16'd0);
      held8 = '0;
    end else if (out_valid8) begin
      if (exp8_q.size() == 0) begin
        check("unexpected_valid8", {15'd0, out_valid8}, 16'd0);
      end else begin
        e = exp8_q.pop_front();
        check("product8", product8, e);
        held8 = e;
      end
    end else begin
      check("hold8", product8, held8);
    end
  end

  // Stimulus
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 4'hF;
    b         = 4'hF;
    in_valid8 = 1'b1;
    a8        = 8'hFF;
    b8        = 8'hFF;

    // Reset held for two cycles with operands presented
    step(1'b1, 1'b1, 4'hF, 4'hF);
    step(1'b1, 1'b1, 4'hF, 4'hF);

    // 8-bit corner pairs go out first after reset
    pend8.push_back({8'd255, 8'd255});
    pend8.push_back({8'd128, 8'd2});
    pend8.push_back({8'd0, 8'd200});
    pend8.push_back({8'd1, 8'd200});

    // Exhaustive 4-bit sweep, back to back
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        step(1'b0, 1'b1, 4'(i), 4'(j));

    // Zero / identity / commutativity and named values
    step(1'b0, 1'b1, 4'd0, 4'd13);
    step(1'b0, 1'b1, 4'd1, 4'd13);
    step(1'b0, 1'b1, 4'd13, 4'd1);
    step(1'b0, 1'b1, 4'd7, 4'd9);
    step(1'b0, 1'b1, 4'd9, 4'd7);
    step(1'b0, 1'b1, 4'd3, 4'd5);
    step(1'b0, 1'b1, 4'd15, 4'd15);
    step(1'b0, 1'b1, 4'd8, 4'd2);

    // Valid gating: 42 must hold while operands change with in_valid low
    step(1'b0, 1'b1, 4'd6, 4'd7);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'd15, 4'd15);

    // Reset on the edge that would capture 4*5, then 10*10 after release
    step(1'b0, 1'b1, 4'd2, 4'd3);
    step(1'b1, 1'b1, 4'd4, 4'd5);
    step(1'b0, 1'b1, 4'd10, 4'd10);
    step(1'b0, 1'b0, 4'd0, 4'd0);

    // Random traffic with occasional resets
    for (int k = 0; k < 300; k++)
      step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    // Drain with a bounded wait
    quiet8 = 1'b1;
    for (int k = 0; k < 10 && (exp_q.size() > 0 || exp8_q.size() > 0); k++)
      step(1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 4'd0, 4'd0);
    check("drain4", 16'(exp_q.size()), 16'd0);
    check("drain8", 16'(exp8_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
